// File: rtl/ro_capture_pkg.sv
// Shared types and constants for the ring-oscillator capture controller.
//   state_e          : controller FSM states
//   LINE_BYTES       : bytes per DMA cache line (address stride)
//   samples_per_line : number of packed counts in one cache line
package ro_capture_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARM    = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_e;

  localparam int LINE_BYTES = 64;
  localparam int LINE_SHIFT = $clog2(LINE_BYTES);

  function automatic int samples_per_line(input int line_width, input int cnt_width);
    return line_width / cnt_width;
  endfunction

endpackage

// File: rtl/ro_sample_packer.sv
// Window timer, baseline register and pack register for RO sampling.
//   start      : load baseline from ro_count and arm the window timer
//   run        : sampling active; one sample per win_len cycles
//   win_len    : window length in clk cycles (caller guarantees >= 1)
//   ro_count   : free-running RO edge counter (binary, clk domain)
//   line_valid : the last slot is being filled this cycle
//   line_data  : pack register including the sample written this cycle
module ro_sample_packer #(
  parameter int CNT_WIDTH  = 16,
  parameter int LINE_WIDTH = 512,
  parameter int WIN_WIDTH  = 16,
  parameter int SPL        = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  run,
  input  logic [WIN_WIDTH-1:0]  win_len,
  input  logic [CNT_WIDTH-1:0]  ro_count,
  output logic                  line_valid,
  output logic [LINE_WIDTH-1:0] line_data
);

  localparam int SLOT_W = (SPL > 1) ? $clog2(SPL) : 1;

  logic [WIN_WIDTH-1:0]  win_cnt_q, win_cnt_d;
  logic [CNT_WIDTH-1:0]  baseline_q, baseline_d;
  logic [SLOT_W-1:0]     slot_q, slot_d;
  logic [LINE_WIDTH-1:0] pack_q, pack_d;
  logic [CNT_WIDTH-1:0]  diff;
  logic                  tick;

  // Modular subtraction makes the count wrap-safe.
  assign diff = ro_count - baseline_q;
  assign tick = run && (win_cnt_q == '0);

  always_comb begin
    win_cnt_d  = win_cnt_q;
    baseline_d = baseline_q;
    slot_d     = slot_q;
    pack_d     = pack_q;
    if (start) begin
      baseline_d = ro_count;
      win_cnt_d  = win_len - WIN_WIDTH'(1);
      slot_d     = '0;
    end else if (tick) begin
      for (int i = 0; i < SPL; i++) begin
        if (slot_q == SLOT_W'(i)) pack_d[i*CNT_WIDTH +: CNT_WIDTH] = diff;
      end
      // Re-baseline on the same edge so consecutive windows abut exactly.
      baseline_d = ro_count;
      win_cnt_d  = win_len - WIN_WIDTH'(1);
      slot_d     = (slot_q == SLOT_W'(SPL-1)) ? '0 : slot_q + SLOT_W'(1);
    end else if (run) begin
      win_cnt_d = win_cnt_q - WIN_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      win_cnt_q  <= '0;
      baseline_q <= '0;
      slot_q     <= '0;
      pack_q     <= '0;
    end else begin
      win_cnt_q  <= win_cnt_d;
      baseline_q <= baseline_d;
      slot_q     <= slot_d;
      pack_q     <= pack_d;
    end
  end

  assign line_valid = tick && (slot_q == SLOT_W'(SPL-1));
  assign line_data  = pack_d;

endmodule

// File: rtl/ro_capture_ctrl.sv
// Ring-oscillator capture run sequencer: samples RO counts over a window,
// packs them into cache lines and writes the lines out over DMA.
//   go / wr_addr / num_samples / window : MMIO run request, latched on go
//   ro_count                            : synchronized RO edge counter
//   dma_wr_full / dma_wr_en / _addr / _data : DMA write channel
//   busy / done / overflow              : run status (overflow is sticky)
//
// state  | meaning
// IDLE   | no run since reset
// ARM    | capture baseline, load window timer
// SAMPLE | sampling, packing and writing lines
// DONE   | all requested lines written
module ro_capture_ctrl
  import ro_capture_pkg::*;
#(
  parameter int ADDR_WIDTH = 64,
  parameter int SIZE_WIDTH = 17,
  parameter int CNT_WIDTH  = 16,
  parameter int LINE_WIDTH = 512,
  parameter int WIN_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  go,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [SIZE_WIDTH-1:0] num_samples,
  input  logic [WIN_WIDTH-1:0]  window,
  input  logic [CNT_WIDTH-1:0]  ro_count,
  input  logic                  dma_wr_full,
  output logic                  dma_wr_en,
  output logic [ADDR_WIDTH-1:0] dma_wr_addr,
  output logic [LINE_WIDTH-1:0] dma_wr_data,
  output logic                  busy,
  output logic                  overflow,
  output logic                  done
);

  localparam int SPL = samples_per_line(LINE_WIDTH, CNT_WIDTH);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic [SIZE_WIDTH-1:0] nsamp_q, nsamp_d;
  logic [SIZE_WIDTH-1:0] line_idx_q, line_idx_d;
  logic [WIN_WIDTH-1:0]  win_q, win_d;
  logic                  out_valid_q, out_valid_d;
  logic [LINE_WIDTH-1:0] out_data_q, out_data_d;
  logic                  overflow_q, overflow_d;
  logic                  pk_start, pk_run;
  logic                  line_valid;
  logic [LINE_WIDTH-1:0] line_data;
  logic                  accept;
  logic                  last_line;
  logic [SIZE_WIDTH-1:0] line_idx_inc;

  ro_sample_packer #(
    .CNT_WIDTH (CNT_WIDTH),
    .LINE_WIDTH(LINE_WIDTH),
    .WIN_WIDTH (WIN_WIDTH),
    .SPL       (SPL)
  ) u_packer (
    .clk       (clk),
    .rst       (rst),
    .start     (pk_start),
    .run       (pk_run),
    .win_len   (win_q),
    .ro_count  (ro_count),
    .line_valid(line_valid),
    .line_data (line_data)
  );

  assign accept       = out_valid_q && !dma_wr_full;
  assign line_idx_inc = line_idx_q + SIZE_WIDTH'(1);
  assign last_line    = (line_idx_inc == nsamp_q);

  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    nsamp_d     = nsamp_q;
    line_idx_d  = line_idx_q;
    win_d       = win_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    overflow_d  = overflow_q;
    pk_start    = 1'b0;
    pk_run      = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (go) begin
          base_d      = wr_addr;
          nsamp_d     = num_samples;
          win_d       = (window == '0) ? WIN_WIDTH'(1) : window;
          line_idx_d  = '0;
          overflow_d  = 1'b0;
          out_valid_d = 1'b0;
          state_d     = (num_samples == '0) ? DONE : ARM;
        end
      end
      ARM: begin
        pk_start = 1'b1;
        state_d  = SAMPLE;
      end
      SAMPLE: begin
        pk_run = 1'b1;
        if (line_valid) begin
          if (!out_valid_q) begin
            out_valid_d = 1'b1;
            out_data_d  = line_data;
          end else if (!(accept && last_line)) begin
            // A line finishing alongside the final write is surplus, not lost.
            overflow_d = 1'b1;
          end
        end
        if (accept) begin
          out_valid_d = 1'b0;
          line_idx_d  = line_idx_inc;
          if (last_line) state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      base_q      <= '0;
      nsamp_q     <= '0;
      line_idx_q  <= '0;
      win_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      nsamp_q     <= nsamp_d;
      line_idx_q  <= line_idx_d;
      win_q       <= win_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      overflow_q  <= overflow_d;
    end
  end

  assign dma_wr_en   = out_valid_q;
  assign dma_wr_addr = base_q + ADDR_WIDTH'({line_idx_q, {LINE_SHIFT{1'b0}}});
  assign dma_wr_data = out_data_q;
  assign busy        = (state_q == ARM) || (state_q == SAMPLE);
  assign done        = (state_q == DONE);
  assign overflow    = overflow_q;

endmodule

// File: tb/tb_ro_capture_ctrl.sv
module tb_ro_capture_ctrl;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         go = 1'b0;
  logic [63:0]  wr_addr = '0;
  logic [16:0]  num_samples = '0;
  logic [15:0]  window = '0;
  logic [15:0]  ro = '0;
  logic         dma_wr_full = 1'b0;
  logic         dma_wr_en;
  logic [63:0]  dma_wr_addr;
  logic [511:0] dma_wr_data;
  logic         busy, overflow, done;

  int n_vec = 0;
  int n_mis = 0;

  always #5 clk = ~clk;

  ro_capture_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .go         (go),
    .wr_addr    (wr_addr),
    .num_samples(num_samples),
    .window     (window),
    .ro_count   (ro),
    .dma_wr_full(dma_wr_full),
    .dma_wr_en  (dma_wr_en),
    .dma_wr_addr(dma_wr_addr),
    .dma_wr_data(dma_wr_data),
    .busy       (busy),
    .overflow   (overflow),
    .done       (done)
  );

  typedef struct {
    int          window;
    int          nsamp;
    int          inc;
    logic [15:0] ro_init;
    logic [63:0] base;
    int          full_start;
    int          full_len;
    bit          noise;
    logic [15:0] exp_sample;
    int          exp_writes;
    int          exp_first_en;
    int          exp_done;
    int          exp_stalls;
    logic        exp_ovf;
  } vec_t;

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [511:0] rep(input logic [15:0] s);
    logic [511:0] v;
    for (int i = 0; i < 32; i++) v[i*16 +: 16] = s;
    return v;
  endfunction

  // k = 0 is the cycle go is presented; ro advances by inc every cycle.
  task automatic run_case(input vec_t v);
    int writes, stalls, first_en, done_at, k, late_en;
    logic [511:0] exp_data;
    exp_data = rep(v.exp_sample);
    ro       = v.ro_init;
    writes = 0; stalls = 0; first_en = -1; done_at = -1; late_en = 0; k = 0;
    while (k <= 2000 && done_at < 0) begin
      @(posedge clk); #1;
      ro = ro + 16'(v.inc);
      go = (k == 0) || (v.noise && k == 10);
      if (k == 0) begin
        wr_addr = v.base; num_samples = 17'(v.nsamp); window = 16'(v.window);
      end
      if (v.noise && k == 10) begin
        wr_addr = 64'hDEAD_0000; num_samples = 17'd5; window = 16'd3;
      end
      dma_wr_full = (k >= v.full_start) && (k < v.full_start + v.full_len);
      if (k == 1) check("busy_after_go", 512'(busy), 512'(v.nsamp != 0));
      if (dma_wr_en) begin
        if (first_en < 0) first_en = k;
        check("wr_addr", 512'(dma_wr_addr), 512'(v.base + 64'(writes) * 64));
        check("wr_data", dma_wr_data, exp_data);
        if (dma_wr_full) stalls++;
        else writes++;
      end
      if (k > 0 && done) done_at = k;
      k++;
    end
    go = 1'b0; dma_wr_full = 1'b0;
    if (done_at < 0) begin
      n_vec++; n_mis++;
      $display("FAIL timeout: done never seen, expected at cycle %0d", v.exp_done);
    end
    check("done_cycle", 512'(done_at), 512'(v.exp_done));
    check("first_en_cycle", 512'(first_en), 512'(v.exp_first_en));
    check("write_count", 512'(writes), 512'(v.exp_writes));
    check("stall_cycles", 512'(stalls), 512'(v.exp_stalls));
    check("overflow", 512'(overflow), 512'(v.exp_ovf));
    check("busy_at_done", 512'(busy), 512'(0));
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (dma_wr_en) late_en++;
    end
    check("no_write_after_done", 512'(late_en), 512'(0));
    check("done_held", 512'(done), 512'(1));
  endtask

  vec_t vecs[7];
  vec_t v_restart;
  int   wr_seen;
  int   en_after_rst;

  initial begin
    //          win nsmp inc ro_init   base              fs   fl  noise smp    wr first done  stall ovf
    vecs[0] = '{4,  2,   3,  16'h0000, 64'h0000_1000,    -1,  0,  0,    16'd12, 2, 130,  259,  0,   1'b0};
    vecs[1] = '{2,  1,   3,  16'hFFF8, 64'h2000_0040,    -1,  0,  0,    16'd6,  1, 66,   67,   0,   1'b0};
    vecs[2] = '{1,  2,   3,  16'h0100, 64'h0000_ABC0,    30,  44, 0,    16'd3,  2, 34,   99,   40,  1'b1};
    vecs[3] = '{0,  1,   5,  16'h0007, 64'h0000_0080,    -1,  0,  0,    16'd5,  1, 34,   35,   0,   1'b0};
    vecs[4] = '{16, 2,   1,  16'h0000, 64'h0004_0000,    514, 10, 0,    16'd16, 2, 514,  1027, 10,  1'b0};
    vecs[5] = '{4,  0,   3,  16'h0000, 64'h0000_0040,    -1,  0,  0,    16'd0,  0, -1,   1,    0,   1'b0};
    vecs[6] = '{4,  1,   2,  16'h0000, 64'h0000_00C0,    -1,  0,  1,    16'd8,  1, 130,  131,  0,   1'b0};
    v_restart = '{1, 1,  3,  16'h0000, 64'h0000_7000,    -1,  0,  0,    16'd3,  1, 34,   35,   0,   1'b0};

    repeat (2) @(posedge clk);
    #1;
    check("rst_ctrl", 512'({dma_wr_en, busy, done, overflow}), 512'(0));
    check("rst_addr", 512'(dma_wr_addr), 512'(0));
    check("rst_data", dma_wr_data, 512'(0));
    rst = 1'b0;

    for (int i = 0; i < 7; i++) run_case(vecs[i]);

    // Reset in the middle of a 3-line run, after line 0 has been written.
    wr_seen = 0;
    ro = '0;
    for (int k = 0; k <= 40; k++) begin
      @(posedge clk); #1;
      ro = ro + 16'd3;
      go = (k == 0);
      if (k == 0) begin
        wr_addr = 64'h7000; num_samples = 17'd3; window = 16'd1;
      end
      if (dma_wr_en) wr_seen++;
    end
    check("lines_before_rst", 512'(wr_seen), 512'(1));
    #3 rst = 1'b1;
    #1;
    check("midrun_rst_ctrl", 512'({dma_wr_en, busy, done, overflow}), 512'(0));
    check("midrun_rst_addr", 512'(dma_wr_addr), 512'(0));
    check("midrun_rst_data", dma_wr_data, 512'(0));
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    en_after_rst = 0;
    for (int k = 0; k < 80; k++) begin
      @(posedge clk); #1;
      ro = ro + 16'd3;
      if (dma_wr_en || busy) en_after_rst++;
    end
    check("quiet_after_rst", 512'(en_after_rst), 512'(0));
    run_case(v_restart);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule

// File: doc/ro_capture_ctrl.md
Name: ro_capture_ctrl

Overview:
- Sequences one ring-oscillator capture run after the MMIO go pulse.
- Each sample is the RO edge count over a programmable window. Samples are packed into cache lines, and each line goes to the DMA write channel at consecutive line addresses from wr_addr.
- Sits between the MMIO register block (go, wr_addr, num_samples, done) and the DMA write interface.
- Adds a sticky overflow status for software.

Parameters:
- ADDR_WIDTH, 64: byte-address width of wr_addr and dma_wr_addr.
- SIZE_WIDTH, 17: width of num_samples. Maximum lines per run is 2**SIZE_WIDTH-1.
- CNT_WIDTH, 16: width of the RO counter and of one packed sample.
- LINE_WIDTH, 512: cache-line width. SAMPLES_PER_LINE = LINE_WIDTH/CNT_WIDTH, which must divide exactly.
- WIN_WIDTH, 16: width of the window-length input.

Ports:
- clk, input, 1: clock.
- rst, input, 1: reset, asynchronous, active-high.
- go, input, 1: single-cycle start pulse.
- wr_addr, input, ADDR_WIDTH: base byte address. Must be 64-byte aligned.
- num_samples, input, SIZE_WIDTH: number of cache lines to write.
- window, input, WIN_WIDTH: clk cycles per sample. 0 is treated as 1.
- ro_count, input, CNT_WIDTH: free-running RO edge counter, already synchronized to clk (binary).
- dma_wr_full, input, 1: DMA write FIFO full. No write is accepted while it is high.
- dma_wr_en, output, 1: write strobe. A write is accepted in any cycle where dma_wr_en=1 and dma_wr_full=0.
- dma_wr_addr, output, ADDR_WIDTH: wr_addr + 64*line_idx.
- dma_wr_data, output, LINE_WIDTH: packed line. Sample 0 occupies bits [CNT_WIDTH-1:0].
- busy, output, 1: high in every state except IDLE and DONE.
- overflow, output, 1: sticky. A completed line was dropped during this run.
- done, output, 1: high in DONE, held until the next accepted go.

Behaviour:
- Reset values: all outputs 0, state IDLE, all counters 0, baseline 0.
- States:
  - IDLE/DONE + go: latch wr_addr, num_samples and max(window,1). Clear done, overflow, line_idx and sample_idx. If latched num_samples==0, go to DONE next cycle; otherwise go to ARM.
  - ARM: capture baseline=ro_count, load win_cnt=window-1, go to SAMPLE.
  - SAMPLE, when win_cnt==0:
    - sample = ro_count - baseline, taken modulo 2**CNT_WIDTH (wrap-safe).
    - Write the sample to slot sample_idx of the pack register.
    - baseline <= ro_count; reload win_cnt.
    - Windows are back-to-back, so no RO edges are lost between samples.
  - SAMPLE, otherwise: decrement win_cnt.
  - Line completion, when slot SAMPLES_PER_LINE-1 is filled:
    - If the output register is empty, move the pack register there and assert dma_wr_en from the next cycle.
    - If the output register is still pending, drop the new line and set overflow. line_idx does not advance; sampling continues.
  - Write accepted: line_idx++ and clear the pending flag. When line_idx reaches num_samples, stop sampling and go to DONE (done=1 the cycle after the final accept). Samples in a partially filled pack register are discarded.
- dma_wr_en, dma_wr_addr and dma_wr_data are held stable while dma_wr_full=1.
- Latency:
  - First sample completes `window` cycles after ARM.
  - First dma_wr_en comes one cycle after the line-completing sample.
- go while busy is ignored.
- MMIO input changes during a run have no effect, because the values are latched at go.
- An asynchronous rst mid-run returns to IDLE with no further writes. A pending line is lost.
- Address arithmetic: dma_wr_addr = base + {line_idx, 6'b0}, truncated to ADDR_WIDTH.

Decomposition:
- Package ro_capture_pkg:
  - state enum (IDLE, ARM, SAMPLE, DONE);
  - SAMPLES_PER_LINE function of the parameters;
  - LINE_BYTES=64 constant.
- Sub-module ro_sample_packer holds the window counter, baseline, difference and pack register. It has outputs line_valid and line_data.
- The FSM, output register and DMA handshake stay in the top.

Test Plan:
- Basic run: window=4, num_samples=2, ro_count +3 per cycle, dma_wr_full=0 → 2 writes at wr_addr and wr_addr+64, every sample 12, then done=1 and overflow=0.
- RO counter wrap: baseline 0xFFFE, window=2, +3 per cycle → sample 6.
- Backpressure: dma_wr_full=1 for 10 cycles on line 0, window=16 → data and address held stable, a single write on release, no overflow.
- Overflow: window=1, dma_wr_full held for 40 cycles → overflow=1, dropped line not counted, run still completes num_samples writes.
- Edge starts:
  - num_samples=0 → done one cycle after IDLE, no writes.
  - window=0 → behaves exactly as window=1.
  - Second go while busy → ignored.
- Reset mid-run after 1 of 3 lines → outputs return to 0, no further dma_wr_en. A new go restarts from line 0.
